// File: rtl/agc_alu_seq.sv
// agc_alu_seq -- sequential ones'-complement arithmetic unit for the AGC datapath.
//
// This unit executes the alu_op code that the control-pulse sequencer issues
// against the X and Y registers.
//   - AD, SU and MASK complete in one cycle.
//   - MP0 runs a 14-step shift/add multiply.
//   - DV0 runs a 14-step restoring divide.
//   - MP1 and DV1 read back the held hi/quotient word.
//
// Words are WIDTH bits wide and ones'-complement:
//   bit W-1 = S2, bit W-2 = S1, low W-2 bits = magnitude.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   start   in   one-cycle request; samples alu_op, x and y while idle
//   alu_op  in   0=AD 1=SU 2=MASK 3=MP0 4=MP1 5=DV0 6=DV1 7=reserved
//   x, y    in   operand words
//   alu_out out  result word to the A mux
//   lp_out  out  low product / remainder to the LP mux
//   ovf     out  overflow / divide fault of the last completed op
//   busy    out  high while an MP0/DV0 iteration is in progress
//   done    out  one-cycle completion pulse
module agc_alu_seq #(
  parameter int WIDTH = 16,
  parameter int STEPS = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] lp_out,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int MW = WIDTH - 2;
  localparam int CW = $clog2(STEPS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIN
  } state_e;

  typedef enum logic [2:0] {
    OP_AD   = 3'd0,
    OP_SU   = 3'd1,
    OP_MASK = 3'd2,
    OP_MP0  = 3'd3,
    OP_MP1  = 3'd4,
    OP_DV0  = 3'd5,
    OP_DV1  = 3'd6,
    OP_RSV  = 3'd7
  } op_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [MW-1:0]     mx_q, mx_d;
  logic [MW-1:0]     my_q, my_d;
  // MUL: {hi, lo} partial product. DIV: {remainder, quotient}.
  logic [2*MW-1:0]   acc_q, acc_d;
  logic              sgn_q, sgn_d;     // product / quotient sign
  logic              rsgn_q, rsgn_d;   // remainder sign
  logic              div_q, div_d;     // operation in flight is a divide
  logic              flt_q, flt_d;     // divide fault pending in FIN
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic [WIDTH-1:0]  alu_q, alu_d;
  logic [WIDTH-1:0]  lp_q, lp_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  function automatic logic [MW-1:0] mag(input logic [WIDTH-1:0] w);
    return w[WIDTH-1] ? ~w[MW-1:0] : w[MW-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sword(input logic s, input logic [MW-1:0] m);
    return {s, s, (s ? ~m : m)};
  endfunction

  // Returns {alu word, lp word} for a finished multiply or divide.
  function automatic logic [2*WIDTH-1:0] pack(input logic is_div, input logic s,
                                              input logic sr, input logic [2*MW-1:0] p);
    if (is_div)
      return {sword(s, p[MW-1:0]), sword(sr, p[2*MW-1:MW])};
    else if (p == '0)
      return '0;
    else
      return {sword(s, p[2*MW-1:MW]), sword(s, p[MW-1:0])};
  endfunction

  // Ones'-complement add with end-around carry (SU adds ~y).
  logic [WIDTH:0]   raw;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] eac;

  // Datapath steps.
  logic [MW-1:0]    mx_c, my_c;
  logic [MW:0]      mul_sum;
  logic [2*MW-1:0]  mul_acc;
  logic [MW:0]      div_t;
  logic             div_ge;
  logic [MW-1:0]    div_r;
  logic [2*MW-1:0]  div_acc;
  logic [2*WIDTH-1:0] pk;
  logic             last_step;

  always_comb begin
    addend  = (alu_op == OP_SU) ? ~y : y;
    raw     = {1'b0, x} + {1'b0, addend};
    eac     = raw[WIDTH-1:0] + WIDTH'(raw[WIDTH]);

    mx_c    = mag(x);
    my_c    = mag(y);

    // Shift-add multiply: the multiplier sits in the low half and is consumed LSB first.
    mul_sum = {1'b0, acc_q[2*MW-1:MW]} + (acc_q[0] ? {1'b0, mx_q} : '0);
    mul_acc = {mul_sum, acc_q[MW-1:1]};

    // Restoring divide: the dividend's low half is all zeros, so only a 0 is shifted in.
    div_t   = {acc_q[2*MW-1:MW], 1'b0};
    div_ge  = (div_t >= {1'b0, my_q});
    div_r   = div_ge ? MW'(div_t - {1'b0, my_q}) : div_t[MW-1:0];
    div_acc = {div_r, acc_q[MW-2:0], div_ge};

    last_step = (cnt_q == CW'(STEPS - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mx_d    = mx_q;
    my_d    = my_q;
    acc_d   = acc_q;
    sgn_d   = sgn_q;
    rsgn_d  = rsgn_q;
    div_d   = div_q;
    flt_d   = flt_q;
    hold_d  = hold_q;
    alu_d   = alu_q;
    lp_d    = lp_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    pk      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (alu_op)
            OP_AD, OP_SU: begin
              alu_d  = eac;
              ovf_d  = eac[WIDTH-1] ^ eac[WIDTH-2];
              done_d = 1'b1;
            end
            OP_MASK: begin
              alu_d  = x & y;
              ovf_d  = 1'b0;
              done_d = 1'b1;
            end
            OP_MP0: begin
              mx_d    = mx_c;
              my_d    = my_c;
              sgn_d   = x[WIDTH-1] ^ y[WIDTH-1];
              div_d   = 1'b0;
              flt_d   = 1'b0;
              acc_d   = {{MW{1'b0}}, my_c};
              cnt_d   = '0;
              state_d = S_MUL;
            end
            OP_DV0: begin
              mx_d   = mx_c;
              my_d   = my_c;
              sgn_d  = x[WIDTH-1] ^ y[WIDTH-1];
              rsgn_d = x[WIDTH-1];
              div_d  = 1'b1;
              cnt_d  = '0;
              if (my_c == '0) begin
                flt_d   = 1'b1;
                acc_d   = {{MW{1'b0}}, {MW{1'b1}}};
                state_d = S_FIN;
              end else if (mx_c >= my_c) begin
                flt_d   = 1'b1;
                acc_d   = {mx_c, {MW{1'b1}}};
                state_d = S_FIN;
              end else begin
                flt_d   = 1'b0;
                acc_d   = {mx_c, {MW{1'b0}}};
                state_d = S_DIV;
              end
            end
            OP_MP1, OP_DV1: begin
              alu_d  = hold_q;
              ovf_d  = 1'b0;
              done_d = 1'b1;
            end
            default: begin
              done_d = 1'b1;
            end
          endcase
        end
      end

      // The last iteration packs its own result straight into the output
      // registers and returns to IDLE, so that done rises 15 cycles after start
      // and the done cycle can accept a new start. FIN is taken only by the
      // divide-fault shortcuts.
      S_MUL: begin
        acc_d = mul_acc;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          pk      = pack(1'b0, sgn_q, rsgn_q, mul_acc);
          alu_d   = pk[2*WIDTH-1:WIDTH];
          lp_d    = pk[WIDTH-1:0];
          hold_d  = pk[2*WIDTH-1:WIDTH];
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      S_DIV: begin
        acc_d = div_acc;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          pk      = pack(1'b1, sgn_q, rsgn_q, div_acc);
          alu_d   = pk[2*WIDTH-1:WIDTH];
          lp_d    = pk[WIDTH-1:0];
          hold_d  = pk[2*WIDTH-1:WIDTH];
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      S_FIN: begin
        pk      = pack(div_q, sgn_q, rsgn_q, acc_q);
        alu_d   = pk[2*WIDTH-1:WIDTH];
        lp_d    = pk[WIDTH-1:0];
        hold_d  = pk[2*WIDTH-1:WIDTH];
        ovf_d   = flt_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      acc_q   <= '0;
      sgn_q   <= 1'b0;
      rsgn_q  <= 1'b0;
      div_q   <= 1'b0;
      flt_q   <= 1'b0;
      hold_q  <= '0;
      alu_q   <= '0;
      lp_q    <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      acc_q   <= acc_d;
      sgn_q   <= sgn_d;
      rsgn_q  <= rsgn_d;
      div_q   <= div_d;
      flt_q   <= flt_d;
      hold_q  <= hold_d;
      alu_q   <= alu_d;
      lp_q    <= lp_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign alu_out = alu_q;
  assign lp_out  = lp_q;
  assign ovf     = ovf_q;
  assign done    = done_q;
  assign busy    = (state_q == S_MUL) || (state_q == S_DIV);

endmodule
